// File: rtl/ethgen_pkg.sv
// Shared types and constants for the GMII-to-32-bit packer: FSM states,
// tmod encodings for both byte orders, the pad byte and lane helpers.
package ethgen_pkg;

    typedef enum logic [1:0] {
        ST_SYNC    = 2'd0,
        ST_IDLE    = 2'd1,
        ST_COLLECT = 2'd2
    } state_e;

    typedef struct packed {
        logic [31:0] data;
        logic        sop;
        logic        eop;
        logic [1:0]  tmod;
        logic        derror;
    } word_t;

    localparam logic [1:0] TMOD_4B    = 2'b00;
    localparam logic [1:0] TMOD_BE_3B = 2'b01;
    localparam logic [1:0] TMOD_BE_2B = 2'b10;
    localparam logic [1:0] TMOD_BE_1B = 2'b11;
    localparam logic [1:0] TMOD_LE_1B = 2'b01;
    localparam logic [1:0] TMOD_LE_2B = 2'b10;
    localparam logic [1:0] TMOD_LE_3B = 2'b11;

    localparam logic [7:0] PAD_BYTE = 8'h00;

    // tmod for a partial word holding idx valid bytes
    function automatic logic [1:0] tmod_enc(input logic be, input logic [1:0] idx);
        logic [1:0] t;
        case (idx)
            2'd1:    t = be ? TMOD_BE_1B : TMOD_LE_1B;
            2'd2:    t = be ? TMOD_BE_2B : TMOD_LE_2B;
            2'd3:    t = be ? TMOD_BE_3B : TMOD_LE_3B;
            default: t = TMOD_4B;
        endcase
        return t;
    endfunction

    function automatic logic [31:0] place_byte(input logic be, input logic [1:0] idx,
                                               input logic [7:0] b);
        logic [1:0] lane;
        if (be) begin
            lane = 2'd3 - idx;
        end else begin
            lane = idx;
        end
        return {24'd0, b} << {lane, 3'd0};
    endfunction

endpackage

// File: rtl/ethgen_pack32_if.sv
// Packed-word output stream of ethgen_pack32: word, framing flags and ready.
interface ethgen_pack32_if;
    logic [31:0] dout;
    logic        dval;
    logic        dout_rdy;
    logic        sop;
    logic        eop;
    logic [1:0]  tmod;
    logic        derror;

    modport master (output dout, dval, sop, eop, tmod, derror, input dout_rdy);
    modport slave  (input dout, dval, sop, eop, tmod, derror, output dout_rdy);
endinterface

// File: rtl/ethgen_word_fifo.sv
// Synchronous show-ahead word FIFO; a push on a full FIFO is accepted only
// when a pop happens in the same cycle.
module ethgen_word_fifo
    import ethgen_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic  clk,
    input  logic  reset,
    input  logic  push,
    input  word_t push_word,
    input  logic  pop,
    output word_t rd_word,
    output logic  full,
    output logic  empty
);

    localparam int AW = (DEPTH > 2) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    word_t       mem_q [DEPTH];
    word_t       mem_d [DEPTH];
    logic [AW:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0] rd_ptr_q, rd_ptr_d;
    logic        do_push_s, do_pop_s;

    // Flags, show-ahead read and pointer/memory next state
    always_comb begin
        empty = (wr_ptr_q == rd_ptr_q);
        full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        if (empty) begin
            rd_word = '0;
        end else begin
            rd_word = mem_q[rd_ptr_q[AW-1:0]];
        end
        do_pop_s  = pop & ~empty;
        do_push_s = push & (~full | pop);
        mem_d     = mem_q;
        if (do_push_s) begin
            mem_d[wr_ptr_q[AW-1:0]] = push_word;
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (do_pop_s) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
    end

    // Storage and pointer registers
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            mem_q    <= mem_d;
        end
    end

endmodule

// File: rtl/ethgen_pack32.sv
// Packs GMII-style byte slots into 32-bit framed words behind a show-ahead FIFO.
// Optional two-byte zero prefix per frame when ETHGEN_PACK_SHIFT16_EN is defined.
module ethgen_pack32
    import ethgen_pkg::*;
#(
    parameter logic BIG_ENDIAN = 1'b1,
    parameter int   FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        txd_en,
    input  logic [7:0]  txd,
    input  logic        tx_dv,
    input  logic        tx_er,
    ethgen_pack32_if.master out_if,
    output logic [15:0] frm_cnt,
    output logic        ovf
);

    state_e      state_q, state_d;
    logic [31:0] acc_q, acc_d;
    logic [1:0]  idx_q, idx_d;
    logic [31:0] pend_q, pend_d;
    logic        pend_vld_q, pend_vld_d;
    logic        pend_sop_q, pend_sop_d;
    logic        first_q, first_d;
    logic        err_q, err_d;
    logic [15:0] frm_cnt_q, frm_cnt_d;
    logic        ovf_q, ovf_d;

    logic        push_s, pop_s, drop_s, full_s, empty_s;
    logic [31:0] acc_byte_s;
    word_t       push_word_s, rd_word_s;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_SYNC;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: only strobed slots move the FSM
    always_comb begin
        state_d = state_q;
        if (txd_en) begin
            case (state_q)
                ST_SYNC:    state_d = tx_dv ? ST_SYNC : ST_IDLE;
                ST_IDLE:    state_d = tx_dv ? ST_COLLECT : ST_IDLE;
                ST_COLLECT: state_d = tx_dv ? ST_COLLECT : ST_IDLE;
                default:    state_d = ST_SYNC;
            endcase
        end else begin
            state_d = state_q;
        end
    end

    // Packing datapath: a completed word waits in pend until the next word starts,
    // so every push lands on a distinct slot
    always_comb begin
        acc_d       = acc_q;
        idx_d       = idx_q;
        pend_d      = pend_q;
        pend_vld_d  = pend_vld_q;
        pend_sop_d  = pend_sop_q;
        first_d     = first_q;
        err_d       = err_q;
        push_s      = 1'b0;
        push_word_s = '0;
        acc_byte_s  = acc_q;
        if (txd_en && (state_q == ST_IDLE) && tx_dv) begin
`ifdef ETHGEN_PACK_SHIFT16_EN
            acc_d = place_byte(BIG_ENDIAN, 2'd0, PAD_BYTE) |
                    place_byte(BIG_ENDIAN, 2'd1, PAD_BYTE) |
                    place_byte(BIG_ENDIAN, 2'd2, txd);
            idx_d = 2'd3;
`else
            acc_d = place_byte(BIG_ENDIAN, 2'd0, txd);
            idx_d = 2'd1;
`endif
            pend_vld_d = 1'b0;
            first_d    = 1'b1;
            err_d      = tx_er;
        end else if (txd_en && (state_q == ST_COLLECT) && tx_dv) begin
            err_d = err_q | tx_er;
            if (idx_q == 2'd0) begin
                acc_byte_s = place_byte(BIG_ENDIAN, 2'd0, txd);
                if (pend_vld_q) begin
                    push_s      = 1'b1;
                    push_word_s = '{data: pend_q, sop: pend_sop_q, eop: 1'b0,
                                    tmod: TMOD_4B, derror: 1'b0};
                    pend_vld_d  = 1'b0;
                end else begin
                    push_s = 1'b0;
                end
            end else begin
                acc_byte_s = acc_q | place_byte(BIG_ENDIAN, idx_q, txd);
            end
            acc_d = acc_byte_s;
            if (idx_q == 2'd3) begin
                pend_d     = acc_byte_s;
                pend_vld_d = 1'b1;
                pend_sop_d = first_q;
                first_d    = 1'b0;
            end else begin
                pend_d = pend_q;
            end
            idx_d = idx_q + 2'd1;
        end else if (txd_en && (state_q == ST_COLLECT) && !tx_dv) begin
            push_s = 1'b1;
            if (idx_q != 2'd0) begin
                push_word_s = '{data: acc_q, sop: first_q, eop: 1'b1,
                                tmod: tmod_enc(BIG_ENDIAN, idx_q), derror: err_q};
            end else begin
                push_word_s = '{data: pend_q, sop: pend_sop_q, eop: 1'b1,
                                tmod: TMOD_4B, derror: err_q};
            end
            pend_vld_d = 1'b0;
            idx_d      = 2'd0;
            acc_d      = 32'd0;
            first_d    = 1'b0;
            err_d      = 1'b0;
        end else begin
            push_s = 1'b0;
        end
    end

    // Frame counter and sticky overflow; a dropped eop still counts
    always_comb begin
        pop_s  = out_if.dval & out_if.dout_rdy;
        drop_s = push_s & full_s & ~pop_s;
        if (push_s && push_word_s.eop) begin
            frm_cnt_d = frm_cnt_q + 16'd1;
        end else begin
            frm_cnt_d = frm_cnt_q;
        end
        ovf_d = ovf_q | drop_s;
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            acc_q      <= 32'd0;
            idx_q      <= 2'd0;
            pend_q     <= 32'd0;
            pend_vld_q <= 1'b0;
            pend_sop_q <= 1'b0;
            first_q    <= 1'b0;
            err_q      <= 1'b0;
            frm_cnt_q  <= 16'd0;
            ovf_q      <= 1'b0;
        end else begin
            acc_q      <= acc_d;
            idx_q      <= idx_d;
            pend_q     <= pend_d;
            pend_vld_q <= pend_vld_d;
            pend_sop_q <= pend_sop_d;
            first_q    <= first_d;
            err_q      <= err_d;
            frm_cnt_q  <= frm_cnt_d;
            ovf_q      <= ovf_d;
        end
    end

    ethgen_word_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push_s),
        .push_word (push_word_s),
        .pop       (out_if.dout_rdy),
        .rd_word   (rd_word_s),
        .full      (full_s),
        .empty     (empty_s)
    );

    assign out_if.dout   = rd_word_s.data;
    assign out_if.dval   = ~empty_s;
    assign out_if.sop    = rd_word_s.sop;
    assign out_if.eop    = rd_word_s.eop;
    assign out_if.tmod   = rd_word_s.tmod;
    assign out_if.derror = rd_word_s.derror;
    assign frm_cnt       = frm_cnt_q;
    assign ovf           = ovf_q;

endmodule

// File: tb/tb_ethgen_pack32.sv
// Scoreboard bench for ethgen_pack32: one big-endian and one little-endian
// instance share the byte stream; expected words are queued per instance.
module tb_ethgen_pack32;

    logic        clk = 1'b0;
    logic        reset;
    logic        txd_en;
    logic [7:0]  txd;
    logic        tx_dv;
    logic        tx_er;
    logic        rdy;
    logic [15:0] be_cnt, le_cnt;
    logic        be_ovf, le_ovf;

    int chk_cnt  = 0;
    int pass_cnt = 0;

    logic [36:0] q_be[$];
    logic [36:0] q_le[$];

    always #5 clk = ~clk;

    ethgen_pack32_if be_if ();
    ethgen_pack32_if le_if ();
    assign be_if.dout_rdy = rdy;
    assign le_if.dout_rdy = rdy;

    ethgen_pack32 #(.BIG_ENDIAN(1'b1), .FIFO_DEPTH(4)) dut_be (
        .clk(clk), .reset(reset), .txd_en(txd_en), .txd(txd), .tx_dv(tx_dv),
        .tx_er(tx_er), .out_if(be_if), .frm_cnt(be_cnt), .ovf(be_ovf));

    ethgen_pack32 #(.BIG_ENDIAN(1'b0), .FIFO_DEPTH(4)) dut_le (
        .clk(clk), .reset(reset), .txd_en(txd_en), .txd(txd), .tx_dv(tx_dv),
        .tx_er(tx_er), .out_if(le_if), .frm_cnt(le_cnt), .ovf(le_ovf));

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        chk_cnt++;
        if (act === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [36:0] ew(input logic [31:0] d, input logic s, input logic e,
                                       input logic [1:0] t, input logic er);
        return {d, s, e, t, er};
    endfunction

    task automatic expect2(input logic [36:0] be_w, input logic [36:0] le_w);
        q_be.push_back(be_w);
        q_le.push_back(le_w);
    endtask

    // Monitor: compares each transferred word against the queue head
    always @(negedge clk) begin
        if (!reset && be_if.dval && rdy) begin
            if (q_be.size() == 0) begin
                chk_cnt++;
                $display("FAIL be_extra_word: got %h expected none", be_if.dout);
            end else begin
                check("be_word", {27'd0, be_if.dout, be_if.sop, be_if.eop, be_if.tmod,
                                  be_if.derror}, {27'd0, q_be.pop_front()});
            end
        end
        if (!reset && le_if.dval && rdy) begin
            if (q_le.size() == 0) begin
                chk_cnt++;
                $display("FAIL le_extra_word: got %h expected none", le_if.dout);
            end else begin
                check("le_word", {27'd0, le_if.dout, le_if.sop, le_if.eop, le_if.tmod,
                                  le_if.derror}, {27'd0, q_le.pop_front()});
            end
        end
    end

    task automatic slot(input logic dv, input logic [7:0] d, input logic er);
        txd_en = 1'b1;
        tx_dv  = dv;
        txd    = d;
        tx_er  = er;
        @(posedge clk);
        #1;
        txd_en = 1'b0;
        tx_dv  = 1'b0;
        txd    = 8'hEE;
        tx_er  = 1'b0;
    endtask

    task automatic gap(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] first, input logic [7:0] step, input int len,
                              input int er_idx, input bit sparse);
        logic [7:0] b;
        b = first;
        for (int i = 0; i < len; i++) begin
            slot(1'b1, b, (i == er_idx));
            b = b + step;
            if (sparse) gap(1);
        end
        slot(1'b0, 8'h00, 1'b0);
    endtask

    task automatic wait_drain(input string nm);
        int n;
        n = 0;
        while ((q_be.size() != 0 || q_le.size() != 0) && n < 100) begin
            @(posedge clk);
            n++;
        end
        #1;
        check(nm, 64'(q_be.size() + q_le.size()), 64'd0);
    endtask

    initial begin
        reset  = 1'b1;
        txd_en = 1'b0;
        tx_dv  = 1'b0;
        txd    = 8'h00;
        tx_er  = 1'b0;
        rdy    = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset_be", {be_if.dval, be_if.dout, be_if.sop, be_if.eop, be_if.tmod,
                           be_if.derror, be_cnt, be_ovf}, 64'd0);
        check("reset_le", {le_if.dval, le_if.dout, le_if.sop, le_if.eop, le_if.tmod,
                           le_if.derror, le_cnt, le_ovf}, 64'd0);
        reset = 1'b0;
        slot(1'b0, 8'h00, 1'b0);

`ifdef ETHGEN_PACK_SHIFT16_EN
        expect2(ew(32'h00000102, 1'b1, 1'b1, 2'b00, 1'b0),
                ew(32'h02010000, 1'b1, 1'b1, 2'b00, 1'b0));
        send_frame(8'h01, 8'h01, 2, -1, 1'b0);
        wait_drain("drain_shift");
        check("frm_cnt_shift", {be_cnt, le_cnt}, {16'd1, 16'd1});
`else
        // 8 bytes with idle non-strobe cycles between slots
        expect2(ew(32'h01020304, 1'b1, 1'b0, 2'b00, 1'b0),
                ew(32'h04030201, 1'b1, 1'b0, 2'b00, 1'b0));
        expect2(ew(32'h05060708, 1'b0, 1'b1, 2'b00, 1'b0),
                ew(32'h08070605, 1'b0, 1'b1, 2'b00, 1'b0));
        send_frame(8'h01, 8'h01, 8, -1, 1'b1);
        wait_drain("drain_a");
        check("frm_cnt_a", {be_cnt, le_cnt}, {16'd1, 16'd1});

        expect2(ew(32'h11121314, 1'b1, 1'b0, 2'b00, 1'b0),
                ew(32'h14131211, 1'b1, 1'b0, 2'b00, 1'b0));
        expect2(ew(32'h15000000, 1'b0, 1'b1, 2'b11, 1'b0),
                ew(32'h00000015, 1'b0, 1'b1, 2'b01, 1'b0));
        send_frame(8'h11, 8'h01, 5, -1, 1'b0);

        expect2(ew(32'hAABBCC00, 1'b1, 1'b1, 2'b01, 1'b1),
                ew(32'h00CCBBAA, 1'b1, 1'b1, 2'b11, 1'b1));
        send_frame(8'hAA, 8'h11, 3, 1, 1'b0);

        expect2(ew(32'h21222324, 1'b1, 1'b1, 2'b00, 1'b0),
                ew(32'h24232221, 1'b1, 1'b1, 2'b00, 1'b0));
        send_frame(8'h21, 8'h01, 4, -1, 1'b0);

        expect2(ew(32'h5A000000, 1'b1, 1'b1, 2'b11, 1'b0),
                ew(32'h0000005A, 1'b1, 1'b1, 2'b01, 1'b0));
        send_frame(8'h5A, 8'h01, 1, -1, 1'b0);
        wait_drain("drain_bcde");
        check("frm_cnt_e", {be_cnt, le_cnt}, {16'd5, 16'd5});

        // Sink stalled: only the first 4 words fit, the rest are dropped
        rdy = 1'b0;
        expect2(ew(32'h30313233, 1'b1, 1'b0, 2'b00, 1'b0),
                ew(32'h33323130, 1'b1, 1'b0, 2'b00, 1'b0));
        expect2(ew(32'h34353637, 1'b0, 1'b0, 2'b00, 1'b0),
                ew(32'h37363534, 1'b0, 1'b0, 2'b00, 1'b0));
        expect2(ew(32'h38393A3B, 1'b0, 1'b0, 2'b00, 1'b0),
                ew(32'h3B3A3938, 1'b0, 1'b0, 2'b00, 1'b0));
        expect2(ew(32'h3C3D3E3F, 1'b0, 1'b0, 2'b00, 1'b0),
                ew(32'h3F3E3D3C, 1'b0, 1'b0, 2'b00, 1'b0));
        send_frame(8'h30, 8'h01, 24, -1, 1'b0);
        gap(3);
        check("ovf_stall", {be_ovf, le_ovf, be_if.dval, le_if.dval}, {1'b1, 1'b1, 1'b1, 1'b1});
        check("frm_cnt_ovf", {be_cnt, le_cnt}, {16'd6, 16'd6});
        rdy = 1'b1;
        wait_drain("drain_ovf");
        gap(3);
        check("empty_after_ovf", {be_if.dval, le_if.dval, be_ovf, le_ovf},
              {1'b0, 1'b0, 1'b1, 1'b1});

        // Reset mid-frame, released while tx_dv is still high
        slot(1'b1, 8'h70, 1'b0);
        slot(1'b1, 8'h71, 1'b0);
        slot(1'b1, 8'h72, 1'b0);
        reset = 1'b1;
        slot(1'b1, 8'h73, 1'b0);
        slot(1'b1, 8'h74, 1'b0);
        check("reset_mid", {be_cnt, le_cnt, be_ovf, le_ovf, be_if.dval, le_if.dval}, 64'd0);
        reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            slot(1'b1, 8'h80 + 8'(i), 1'b0);
        end
        gap(4);
        check("sync_no_words", {be_if.dval, le_if.dval, be_cnt, le_cnt}, 64'd0);
        slot(1'b0, 8'h00, 1'b0);
        expect2(ew(32'h61626364, 1'b1, 1'b1, 2'b00, 1'b0),
                ew(32'h64636261, 1'b1, 1'b1, 2'b00, 1'b0));
        send_frame(8'h61, 8'h01, 4, -1, 1'b0);
        wait_drain("drain_rst");
        check("frm_cnt_rst", {be_cnt, le_cnt}, {16'd1, 16'd1});
`endif

        gap(2);
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/ethgen_pack32.md
ETHGEN_PACK32 -- requirements
Module: ethgen_pack32

Interface
REQ-001 Parameter BIG_ENDIAN, default 1'b1, selects big-endian byte lane order and tmod encoding on dout.
REQ-002 Parameter FIFO_DEPTH, default 4, is the number of 32-bit output words buffered (power of two, minimum 2).
REQ-003 clk  input  1  single clock for all logic.
REQ-004 reset  input  1  synchronous active-high reset.
REQ-005 txd_en  input  1  byte-slot strobe; txd/tx_dv/tx_er are sampled only when high.
REQ-006 txd  input  8  GMII-style transmit byte.
REQ-007 tx_dv  input  1  frame-valid level; frame = contiguous sampled slots with tx_dv=1.
REQ-008 tx_er  input  1  byte error flag.
REQ-009 dout  output  32  packed word.
REQ-010 dval  output  1  dout/sop/eop/tmod/derror valid.
REQ-011 dout_rdy  input  1  sink ready; a word transfers when dval & dout_rdy.
REQ-012 sop / eop  output  1 each  first / last word of frame.
REQ-013 tmod  output  2  valid-byte modulo of the eop word.
REQ-014 derror  output  1  asserted with eop when any byte of the frame had tx_er=1.
REQ-015 frm_cnt  output  16  count of eop words pushed; ovf  output  1  sticky overflow.

Function
REQ-016 States: SYNC (wait for slot with tx_dv=0), IDLE, COLLECT; reset enters SYNC, so a frame already in progress at reset release is discarded.
REQ-017 IDLE->COLLECT on a slot with tx_dv=1; COLLECT->IDLE on a slot with tx_dv=0; non-strobe cycles never change state.
REQ-018 Byte index counter 0..3 wraps; a completed word moves to a pending register.
REQ-019 The pending word is pushed (eop=0) on the slot that supplies the first byte of the next word, so at most one push occurs per cycle.
REQ-020 On frame end: index>0 pushes the partial word with eop=1 (pending already pushed); index=0 pushes the pending word with eop=1, tmod=00.
REQ-021 sop=1 on the first pushed word of each frame; a 1- to 4-byte frame yields one word with sop=eop=1.
REQ-022 BIG_ENDIAN=1: first byte in dout[31:24]; tmod 00=4, 01=3, 10=2, 11=1 valid bytes, MSB-justified.
REQ-023 BIG_ENDIAN=0: first byte in dout[7:0]; tmod 00=4, 01=1, 10=2, 11=3 valid bytes, LSB-justified.
REQ-024 Unused byte lanes of a partial word are 8'h00.
REQ-025 FIFO is show-ahead; a pushed word is visible on dout the cycle after the push; dval = FIFO non-empty.
REQ-026 Simultaneous push and pop when full is accepted with no loss.
REQ-027 Push while full and no pop: word dropped, ovf set until reset, frm_cnt still increments on a dropped eop.
REQ-028 frm_cnt wraps 16'hFFFF->0.

Reset
REQ-029 On reset: dout=0, dval=0, sop=0, eop=0, tmod=0, derror=0, frm_cnt=0, ovf=0, FIFO empty, index=0, pending cleared, state=SYNC; reset mid-frame discards all partial data.

Configuration
REQ-030 Macro ETHGEN_PACK_SHIFT16_EN defined: each frame is prefixed with two 8'h00 bytes before its first received byte, counted in word packing and tmod.
REQ-031 Macro undefined: no prefix; logic for the prefix is absent.

Structure
REQ-032 Shared package ethgen_pkg holds state enum, tmod encoding constants for both endian modes, and the pad byte constant.
REQ-033 Output buffer is sub-module ethgen_word_fifo (synchronous, show-ahead, full/empty flags); packing FSM lives in ethgen_pack32.

Verification
REQ-034 BE, 8-byte frame 01..08, dout_rdy=1 -> words 32'h01020304 (sop) and 32'h05060708 (eop, tmod=00), frm_cnt=1.
REQ-035 LE, 5-byte frame 11..15 -> 32'h14131211 (sop), 32'h00000015 (eop, tmod=01).
REQ-036 BE, 3-byte frame AA BB CC with tx_er on byte 2 -> single word 32'hAABBCC00, sop=eop=1, tmod=01, derror=1.
REQ-037 dout_rdy=0, 24-byte frame, FIFO_DEPTH=4 -> 4 words held, remaining pushes dropped, ovf=1; dout_rdy=1 drains exactly 4 words.
REQ-038 Reset asserted mid-frame, released with tx_dv=1 -> no words output until tx_dv=0 slot; next 4-byte frame yields one sop/eop word.
REQ-039 ETHGEN_PACK_SHIFT16_EN, BE, 2-byte frame 01 02 -> 32'h00000102, sop=eop=1, tmod=00.
